pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Y86 program-counter sequencer that drives `PC` into the combinational instruction memory and consumes its decoded fields (`icode`, `ifun`, `rA`, `rB`, `valC`).
- From those fields it computes the instruction length and `valP`, then selects the next PC: sequential, jump, call or return.
- Tracks processor status: running, halted, invalid instruction, address error.
- Sits in the fetch stage and is the initiator whose responder is the instruction memory.

Parameters:
- DATA_WID, 32: width of PC, `valC`, `valP` and the return-address path.
- RESET_PC, 0: PC value loaded on reset.
- MEM_BYTES, 1024: instruction memory size in bytes; bounds the address check.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- stall  in  1  hold the current instruction; no PC update.
- icode  in  4  instruction code from memory at `PC`.
- ifun  in  4  function code from memory at `PC`.
- rA  in  4  register A field (pass-through use only: 0xF means none).
- rB  in  4  register B field.
- valC  in  DATA_WID  constant / jump target from memory.
- cnd  in  1  branch condition from execute, valid in the same cycle as a jXX.
- ret_valid  in  1  return address on `ret_addr` is valid.
- ret_addr  in  DATA_WID  return address read from the stack.
- PC  out  DATA_WID  registered program counter.
- valP  out  DATA_WID  combinational: `PC` + instruction length.
- instr_valid  out  1  combinational: current instruction is accepted this cycle.
- stat  out  2  registered status: 00 AOK, 01 HLT, 10 INS, 11 ADR.

Behaviour:
- Reset (synchronous, active-high on `rst` at a `clk` edge, dominates everything, including mid-RET-wait):
  - PC <= RESET_PC, state <= RUN, stat <= 00.
  - Combinational outputs then follow from PC and the inputs.
- Instruction length by `icode`:
  - 0 halt: 1
  - 1 nop: 1
  - 2 rrmovl/cmov: 2
  - 3 irmovl: 6
  - 4 rmmovl: 6
  - 5 mrmovl: 6
  - 6 OPl: 2
  - 7 jXX: 5
  - 8 call: 5
  - 9 ret: 1
  - A pushl: 2
  - B popl: 2
  - C–F: illegal.
- `valP` = PC + length, modulo 2^DATA_WID. For an illegal `icode`, `valP` = PC.
- Address error: PC + length > MEM_BYTES for a legal `icode`.
- Legal `ifun`:
  - `icode` 2 and 7: `ifun` 0–6.
  - `icode` 6: `ifun` 0–3.
  - All others: `ifun` must be 0.
  - Any other `ifun` is illegal.
- States: RUN, RET_WAIT, HALT, ERR.
- RUN with `stall`=1: PC and state hold; `instr_valid`=0.
- RUN with `stall`=0, `instr_valid`=1, next PC at the edge:
  - `icode` 7 with (`ifun`==0 or `cnd`==1): PC <= `valC`.
  - `icode` 7 otherwise: PC <= `valP`.
  - `icode` 8: PC <= `valC` (`valP` is the pushed return address).
  - `icode` 9: PC holds; state <= RET_WAIT.
  - `icode` 0: PC holds; state <= HALT; stat <= 01.
  - Others: PC <= `valP`.
- RUN with `stall`=0 and an illegal `icode`/`ifun`: state <= ERR, stat <= 10, PC holds, `instr_valid`=0.
- RUN with `stall`=0 and an address error: state <= ERR, stat <= 11, PC holds, `instr_valid`=0. INS takes priority over ADR.
- RET_WAIT:
  - `instr_valid`=0.
  - `ret_valid`=1: PC <= `ret_addr`, state <= RUN.
  - `stall` does not block the handshake.
- HALT and ERR: terminal until `rst`. PC, stat hold; `instr_valid`=0; all inputs ignored.
- `instr_valid` = (state==RUN) & !`stall` & legal & !address error.
- Halt counts as valid for exactly one cycle.
- One instruction accepted per cycle maximum; zero-latency decode (memory combinational).

Test Plan:
- Reset, then nop at 0, irmovl at 1, OPl at 7 with no stall -> PC sequence 0, 1, 7, 9; `valP` 1, 7, 9; stat 00.
- jXX `ifun`=1 at PC 0x10 with `valC`=0x40: `cnd`=0 -> PC 0x15; repeat with `cnd`=1 -> PC 0x40; `ifun`=0 with `cnd`=0 -> PC 0x40.
- call at 0x20 with `valC`=0x80 -> `valP` 0x25, PC 0x80; then ret -> PC holds 0x80 for 3 cycles with `ret_valid`=0, `instr_valid`=0; `ret_valid`=1 with `ret_addr`=0x25 -> PC 0x25 next cycle.
- halt at 0x30 -> `instr_valid`=1 for one cycle, then stat 01, PC stays 0x30 for 10 cycles regardless of `stall`/`cnd`; `rst` -> PC 0, stat 00.
- `icode`=0xD -> stat 10, PC frozen; OPl with `ifun`=5 -> stat 10; irmovl at PC 1020 with MEM_BYTES=1024 -> stat 11.
- `stall`=1 for 4 cycles during irmovl at 0x8 -> PC stays 0x8, `instr_valid`=0; release -> PC 0xE. Assert `rst` during RET_WAIT -> PC 0, state RUN.

Source files
------------

// File: rtl/pc_sequencer.sv
// Y86 fetch-stage program-counter sequencer: decodes instruction length, forms valP,
// selects the next PC (sequential / jump / call / return) and tracks processor status.
module pc_sequencer #(
  parameter int                  DATA_WID  = 32,
  parameter logic [DATA_WID-1:0] RESET_PC  = {DATA_WID{1'b0}},
  parameter int                  MEM_BYTES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                stall,
  input  logic [3:0]          icode,
  input  logic [3:0]          ifun,
  input  logic [3:0]          rA,
  input  logic [3:0]          rB,
  input  logic [DATA_WID-1:0] valC,
  input  logic                cnd,
  input  logic                ret_valid,
  input  logic [DATA_WID-1:0] ret_addr,
  output logic [DATA_WID-1:0] PC,
  output logic [DATA_WID-1:0] valP,
  output logic                instr_valid,
  output logic [1:0]          stat
);

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_RET_WAIT = 2'd1;
  localparam logic [1:0] ST_HALT     = 2'd2;
  localparam logic [1:0] ST_ERR      = 2'd3;

  localparam logic [1:0] STAT_AOK = 2'b00;
  localparam logic [1:0] STAT_HLT = 2'b01;
  localparam logic [1:0] STAT_INS = 2'b10;
  localparam logic [1:0] STAT_ADR = 2'b11;

  localparam logic [DATA_WID:0] MEM_LIMIT = (DATA_WID+1)'(MEM_BYTES);

  // Length 0 marks an illegal icode.
  function automatic logic [2:0] instr_len(input logic [3:0] code);
    case (code)
      4'h0, 4'h1, 4'h9:         instr_len = 3'd1;
      4'h2, 4'h6, 4'hA, 4'hB:   instr_len = 3'd2;
      4'h3, 4'h4, 4'h5:         instr_len = 3'd6;
      4'h7, 4'h8:               instr_len = 3'd5;
      default:                  instr_len = 3'd0;
    endcase
  endfunction

  function automatic logic ifun_legal(input logic [3:0] code, input logic [3:0] fn);
    case (code)
      4'h2, 4'h7: ifun_legal = (fn <= 4'd6);
      4'h6:       ifun_legal = (fn <= 4'd3);
      default:    ifun_legal = (fn == 4'd0);
    endcase
  endfunction

  logic [1:0]          state_r;
  logic [1:0]          state_nxt_s;
  logic [1:0]          stat_nxt_s;
  logic [DATA_WID-1:0] pc_nxt_s;
  logic [2:0]          len_s;
  logic                icode_ok_s;
  logic                legal_s;
  logic [DATA_WID:0]   sum_s;
  logic                adr_err_s;
  logic                unused_s;

  assign unused_s    = ^{rA, rB};
  assign len_s       = instr_len(icode);
  assign icode_ok_s  = (len_s != 3'd0);
  assign legal_s     = icode_ok_s & ifun_legal(icode, ifun);
  // One extra bit so the bounds check cannot be fooled by wraparound.
  assign sum_s       = {1'b0, PC} + {{(DATA_WID-2){1'b0}}, len_s};
  assign adr_err_s   = icode_ok_s & (sum_s > MEM_LIMIT);
  assign valP        = icode_ok_s ? sum_s[DATA_WID-1:0] : PC;
  assign instr_valid = (state_r == ST_RUN) & ~stall & legal_s & ~adr_err_s;

  // Next-state, next-PC and next-status selection.
  always_comb begin
    pc_nxt_s    = PC;
    state_nxt_s = state_r;
    stat_nxt_s  = stat;
    case (state_r)
      ST_RUN: begin
        if (stall) begin
          pc_nxt_s = PC;
        end else if (!legal_s) begin
          state_nxt_s = ST_ERR;
          stat_nxt_s  = STAT_INS;
        end else if (adr_err_s) begin
          state_nxt_s = ST_ERR;
          stat_nxt_s  = STAT_ADR;
        end else begin
          case (icode)
            4'h7: begin
              if ((ifun == 4'h0) || cnd) begin
                pc_nxt_s = valC;
              end else begin
                pc_nxt_s = valP;
              end
            end
            4'h8: pc_nxt_s = valC;
            4'h9: state_nxt_s = ST_RET_WAIT;
            4'h0: begin
              state_nxt_s = ST_HALT;
              stat_nxt_s  = STAT_HLT;
            end
            default: pc_nxt_s = valP;
          endcase
        end
      end
      ST_RET_WAIT: begin
        if (ret_valid) begin
          pc_nxt_s    = ret_addr;
          state_nxt_s = ST_RUN;
        end else begin
          pc_nxt_s = PC;
        end
      end
      ST_HALT: state_nxt_s = ST_HALT;
      ST_ERR:  state_nxt_s = ST_ERR;
      default: begin
        state_nxt_s = ST_ERR;
        stat_nxt_s  = STAT_INS;
      end
    endcase
  end

  // Architectural state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      PC      <= RESET_PC;
      state_r <= ST_RUN;
      stat    <= STAT_AOK;
    end else begin
      PC      <= pc_nxt_s;
      state_r <= state_nxt_s;
      stat    <= stat_nxt_s;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed walk through the main scenarios,
// then randomized instruction streams checked against a table-driven reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst, stall, cnd, ret_valid;
  logic [3:0]  icode, ifun, rA, rB;
  logic [31:0] valC, ret_addr, PC, valP;
  logic        instr_valid;
  logic [1:0]  stat;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int M_RUN = 0, M_RETW = 1, M_HALT = 2, M_ERR = 3;
  int          m_mode;
  logic [31:0] m_pc;
  logic [1:0]  m_stat;

  int len_tab[16]  = '{1, 1, 2, 6, 6, 6, 2, 5, 5, 1, 2, 2, 0, 0, 0, 0};
  int ifun_max[16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, 0, 0, 0, 0};

  always #5 clk = ~clk;

  pc_sequencer #(.DATA_WID(32), .RESET_PC(32'h0), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst(rst), .stall(stall), .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
    .valC(valC), .cnd(cnd), .ret_valid(ret_valid), .ret_addr(ret_addr),
    .PC(PC), .valP(valP), .instr_valid(instr_valid), .stat(stat)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus: check combinational outputs, advance model, check registers.
  task automatic step(input logic [3:0] ic, input logic [3:0] fn, input logic stl,
                      input logic c, input logic rv, input logic [31:0] vc,
                      input logic [31:0] ra, input logic r);
    longint nxt;
    int     len;
    bit     legal, adr, iv, take;
    @(negedge clk);
    icode = ic; ifun = fn; stall = stl; cnd = c; ret_valid = rv;
    valC = vc; ret_addr = ra; rst = r;
    rA = 4'($urandom); rB = 4'($urandom);
    len   = len_tab[ic];
    legal = (len != 0) && (int'(fn) <= ifun_max[ic]);
    nxt   = longint'(m_pc) + longint'(len);
    adr   = (len != 0) && (nxt > 64'd1024);
    iv    = (m_mode == M_RUN) && !stl && legal && !adr;
    #1;
    check_eq("valP", valP, nxt[31:0]);
    check_eq("instr_valid", 32'(instr_valid), 32'(iv));
    if (r) begin
      m_pc = 32'h0; m_mode = M_RUN; m_stat = 2'b00;
    end else if (m_mode == M_RUN && !stl) begin
      if (!legal) begin
        m_mode = M_ERR; m_stat = 2'b10;
      end else if (adr) begin
        m_mode = M_ERR; m_stat = 2'b11;
      end else begin
        take = (fn == 4'h0) || c;
        if (ic == 4'h7)      m_pc = take ? vc : nxt[31:0];
        else if (ic == 4'h8) m_pc = vc;
        else if (ic == 4'h9) m_mode = M_RETW;
        else if (ic == 4'h0) begin m_mode = M_HALT; m_stat = 2'b01; end
        else                 m_pc = nxt[31:0];
      end
    end else if (m_mode == M_RETW && rv) begin
      m_pc = ra; m_mode = M_RUN;
    end
    @(posedge clk);
    #1;
    check_eq("PC", PC, m_pc);
    check_eq("stat", 32'(stat), 32'(m_stat));
  endtask

  task automatic run_instr(input logic [3:0] ic, input logic [3:0] fn, input logic [31:0] vc);
    step(ic, fn, 1'b0, 1'b0, 1'b0, vc, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
  endtask

  // Reset then unconditional jump to addr.
  task automatic goto(input logic [31:0] addr);
    do_reset();
    run_instr(4'h7, 4'h0, addr);
  endtask

  initial begin
    logic [3:0] ic, fn;
    logic       r;
    rst = 1'b1; stall = 1'b0; cnd = 1'b0; ret_valid = 1'b0;
    icode = 4'h1; ifun = 4'h0; rA = 4'hF; rB = 4'hF; valC = 32'h0; ret_addr = 32'h0;
    @(posedge clk);
    #1;
    m_pc = 32'h0; m_mode = M_RUN; m_stat = 2'b00;
    check_eq("reset_pc", PC, 32'h0);
    check_eq("reset_stat", 32'(stat), 32'h0);

    // Sequential: nop, irmovl, OPl
    run_instr(4'h1, 4'h0, 32'h0);
    check_eq("seq_pc1", PC, 32'h1);
    run_instr(4'h3, 4'h0, 32'h1234);
    check_eq("seq_pc7", PC, 32'h7);
    run_instr(4'h6, 4'h2, 32'h0);
    check_eq("seq_pc9", PC, 32'h9);

    // Conditional and unconditional jumps
    goto(32'h10);
    step(4'h7, 4'h1, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    check_eq("jxx_nt", PC, 32'h15);
    goto(32'h10);
    step(4'h7, 4'h1, 1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    check_eq("jxx_t", PC, 32'h40);
    goto(32'h10);
    step(4'h7, 4'h0, 1'b0, 1'b0, 1'b0, 32'h40, 32'h0, 1'b0);
    check_eq("jmp", PC, 32'h40);

    // Call then return with a delayed handshake
    goto(32'h20);
    run_instr(4'h8, 4'h0, 32'h80);
    check_eq("call_pc", PC, 32'h80);
    run_instr(4'h9, 4'h0, 32'h0);
    for (int i = 0; i < 3; i++) step(4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h25, 1'b0);
    check_eq("retw_pc", PC, 32'h80);
    step(4'h1, 4'h0, 1'b1, 1'b0, 1'b1, 32'h0, 32'h25, 1'b0);
    check_eq("ret_pc", PC, 32'h25);

    // Halt is terminal until reset
    goto(32'h30);
    run_instr(4'h0, 4'h0, 32'h0);
    for (int i = 0; i < 10; i++)
      step(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
           $urandom, $urandom, 1'b0);
    check_eq("halt_pc", PC, 32'h30);
    check_eq("halt_stat", 32'(stat), 32'h1);
    do_reset();
    check_eq("halt_rst", PC, 32'h0);

    // Illegal icode, illegal ifun, address error
    do_reset();
    run_instr(4'hD, 4'h0, 32'h0);
    check_eq("ins_icode", 32'(stat), 32'h2);
    do_reset();
    run_instr(4'h6, 4'h5, 32'h0);
    check_eq("ins_ifun", 32'(stat), 32'h2);
    goto(32'd1020);
    run_instr(4'h3, 4'h0, 32'h0);
    check_eq("adr_stat", 32'(stat), 32'h3);
    check_eq("adr_pc", PC, 32'd1020);

    // Stall, then reset during RET_WAIT
    goto(32'h8);
    for (int i = 0; i < 4; i++) step(4'h3, 4'h0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    check_eq("stall_pc", PC, 32'h8);
    run_instr(4'h3, 4'h0, 32'h0);
    check_eq("unstall_pc", PC, 32'hE);
    run_instr(4'h9, 4'h0, 32'h0);
    do_reset();
    run_instr(4'h1, 4'h0, 32'h0);
    check_eq("retw_rst", PC, 32'h1);

    // Randomized instruction stream
    for (int i = 0; i < 2000; i++) begin
      ic = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(12, 15)) : 4'($urandom_range(0, 11));
      fn = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, ifun_max[ic]));
      if (m_mode == M_HALT || m_mode == M_ERR) r = ($urandom_range(0, 3) == 0);
      else                                     r = ($urandom_range(0, 60) == 0);
      step(ic, fn, ($urandom_range(0, 4) == 0), 1'($urandom), ($urandom_range(0, 2) == 0),
           32'($urandom_range(0, 1100)), 32'($urandom_range(0, 1100)), r);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
